// File: rtl/exec_datapath.sv
// ============================================================================
// exec_datapath: single-cycle 8-bit execution datapath (4 x 8 register file,
// ALU, registered {N,C,V,Z} flags, OUT latch).          Revision: 1.0
// ============================================================================
`default_nettype none

module exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Instr,
  output logic [3:0]  ALUFlags,
  output logic [7:0]  DataOut
);

  logic [3:0][7:0] rf_q, rf_d;
  logic [3:0]      flags_q, flags_d;
  logic [7:0]      dout_q, dout_d;

  logic [3:0] opcode;
  logic [1:0] rd, rs;
  logic [7:0] imm;
  logic [7:0] op_a, op_b;
  logic [8:0] sum9, diff9, shl9, shr9;
  logic [7:0] result;
  logic       c_flag, v_flag, upd, wr;

  always_comb begin
    opcode = Instr[15:12];
    rd     = Instr[11:10];
    rs     = Instr[9:8];
    imm    = Instr[7:0];
    op_a   = rf_q[rd];
    op_b   = (opcode == 4'h8 || opcode == 4'h9 || opcode == 4'hB) ? imm : rf_q[rs];

    sum9   = {1'b0, op_a} + {1'b0, op_b};
    diff9  = {1'b0, op_a} - {1'b0, op_b};
    // Shift through a 9th bit so the last bit shifted out lands in a fixed
    // position; a zero shift amount naturally leaves that bit clear.
    shl9   = {1'b0, op_a} << imm[2:0];
    shr9   = {op_a, 1'b0} >> imm[2:0];

    rf_d    = rf_q;
    flags_d = flags_q;
    dout_d  = dout_q;
    result  = 8'h00;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    upd     = 1'b0;
    wr      = 1'b0;

    case (opcode)
      4'h1: begin result = imm;  wr = 1'b1; end
      4'h2: begin result = op_b; wr = 1'b1; end
      4'h3, 4'h8: begin
        result = sum9[7:0];
        c_flag = sum9[8];
        v_flag = (op_a[7] == op_b[7]) && (result[7] != op_a[7]);
        upd    = 1'b1;
        wr     = 1'b1;
      end
      4'h4, 4'h9, 4'hA, 4'hB: begin
        result = diff9[7:0];
        c_flag = ~diff9[8];
        v_flag = (op_a[7] != op_b[7]) && (result[7] != op_a[7]);
        upd    = 1'b1;
        wr     = (opcode == 4'h4) || (opcode == 4'h9);
      end
      4'h5: begin result = op_a & op_b; upd = 1'b1; wr = 1'b1; end
      4'h6: begin result = op_a | op_b; upd = 1'b1; wr = 1'b1; end
      4'h7: begin result = op_a ^ op_b; upd = 1'b1; wr = 1'b1; end
      4'hC: begin
        result = shl9[7:0];
        c_flag = shl9[8];
        upd    = 1'b1;
        wr     = 1'b1;
      end
      4'hD: begin
        result = shr9[8:1];
        c_flag = shr9[0];
        upd    = 1'b1;
        wr     = 1'b1;
      end
      4'hE: dout_d = op_a;
      default: ;
    endcase

    if (wr)  rf_d[rd] = result;
    if (upd) flags_d  = {result[7], c_flag, v_flag, (result == 8'h00)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q    <= '0;
      flags_q <= 4'b0000;
      dout_q  <= 8'h00;
    end else begin
      rf_q    <= rf_d;
      flags_q <= flags_d;
      dout_q  <= dout_d;
    end
  end

  assign ALUFlags = flags_q;
  assign DataOut  = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_datapath.sv
// ============================================================================
// tb_exec_datapath: directed + randomized self-checking bench for
// exec_datapath against an arithmetic reference model.   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Instr = 16'h0000;
  logic [3:0]  ALUFlags;
  logic [7:0]  DataOut;

  int n_vec = 0;
  int n_err = 0;

  int         m_r[4];
  logic [3:0] m_flags;
  int         m_dout;

  exec_datapath dut (
    .clk     (clk),
    .reset   (reset),
    .Instr   (Instr),
    .ALUFlags(ALUFlags),
    .DataOut (DataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
    logic [15:0] w;
    w[15:12] = op[3:0];
    w[11:10] = rd[1:0];
    w[9:8]   = rs[1:0];
    w[7:0]   = imm[7:0];
    return w;
  endfunction

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_flags = 4'b0000;
    m_dout  = 0;
  endtask

  task automatic model_exec(input logic [15:0] ins);
    int op, rd, rs, imm, a, b, res, sv, amt;
    bit c, v, upd, wr;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:10]);
    rs  = int'(ins[9:8]);
    imm = int'(ins[7:0]);
    amt = imm % 8;
    a   = m_r[rd];
    b   = (op == 8 || op == 9 || op == 11) ? imm : m_r[rs];
    res = 0; c = 0; v = 0; upd = 1; wr = 1;
    case (op)
      1:  begin res = imm; upd = 0; end
      2:  begin res = m_r[rs]; upd = 0; end
      3, 8: begin
        res = (a + b) % 256;
        c   = (a + b) > 255;
        sv  = sgn(a) + sgn(b);
        v   = (sv > 127) || (sv < -128);
      end
      4, 9, 10, 11: begin
        res = (a - b + 256) % 256;
        c   = (a >= b);
        sv  = sgn(a) - sgn(b);
        v   = (sv > 127) || (sv < -128);
        wr  = (op == 4 || op == 9);
      end
      5:  res = a & b;
      6:  res = a | b;
      7:  res = a ^ b;
      12: begin
        res = (a * (1 << amt)) % 256;
        c   = (amt > 0) ? ((a >> (8 - amt)) % 2 == 1) : 1'b0;
      end
      13: begin
        res = a >> amt;
        c   = (amt > 0) ? ((a >> (amt - 1)) % 2 == 1) : 1'b0;
      end
      14: begin m_dout = a; upd = 0; wr = 0; end
      default: begin upd = 0; wr = 0; end
    endcase
    if (wr) m_r[rd] = res;
    if (upd) m_flags = {res >= 128, c, v, res == 0};
  endtask

  // Apply one instruction across a rising edge, then compare outputs to the model.
  task automatic step(input logic [15:0] ins);
    Instr = ins;
    @(posedge clk);
    #1;
    model_exec(ins);
    check($sformatf("flags[%04h]", ins), {4'b0000, ALUFlags}, {4'b0000, m_flags});
    check($sformatf("dout[%04h]", ins), DataOut, m_dout[7:0]);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    repeat (4) begin
      Instr = 16'($urandom);
      @(posedge clk);
      #1;
      check("reset_flags", {4'b0000, ALUFlags}, 8'h00);
      check("reset_dout", DataOut, 8'h00);
    end
    #2 reset = 1'b1;

    step(enc(1, 2, 0, 8'h3C));
    step(enc(14, 2, 0, 0));
    check("out_r2", DataOut, 8'h3C);

    step(enc(1, 0, 0, 8'h7F));
    step(enc(1, 1, 0, 8'h01));
    step(enc(3, 0, 1, 0));
    check("add_ovf_flags", {4'b0000, ALUFlags}, 8'h0A);
    step(enc(14, 0, 0, 0));
    check("add_ovf_r0", DataOut, 8'h80);

    step(enc(1, 0, 0, 8'h00));
    step(enc(9, 0, 0, 8'h01));
    check("subi_borrow_flags", {4'b0000, ALUFlags}, 8'h08);
    step(enc(1, 1, 0, 8'h05));
    step(enc(11, 1, 0, 8'h05));
    check("cmpi_eq_flags", {4'b0000, ALUFlags}, 8'h05);
    step(enc(14, 1, 0, 0));
    check("cmpi_r1_kept", DataOut, 8'h05);

    step(enc(1, 3, 0, 8'h81));
    step(enc(12, 3, 0, 8'h01));
    check("lsl_flags", {4'b0000, ALUFlags}, 8'h04);
    step(enc(2, 0, 3, 0));
    step(enc(0, 0, 0, 0));
    check("hold_flags", {4'b0000, ALUFlags}, 8'h04);
    step(enc(13, 3, 0, 8'h02));
    check("lsr_flags", {4'b0000, ALUFlags}, 8'h05);

    step(enc(1, 0, 0, 3));
    step(enc(1, 1, 0, 1));
    for (int i = 0; i < 3; i++) begin
      step(enc(4, 0, 1, 0));
      check($sformatf("loop_z%0d", i), {7'b0, ALUFlags[0]}, (i == 2) ? 8'h01 : 8'h00);
    end
    step(enc(1, 2, 0, 8'h5A));
    step(enc(4, 2, 2, 0));
    check("sub_self_z", {7'b0, ALUFlags[0]}, 8'h01);

    // Asynchronous reset in the middle of an ADD sequence.
    step(enc(1, 0, 0, 8'h40));
    step(enc(1, 1, 0, 8'hC1));
    step(enc(3, 0, 1, 0));
    step(enc(14, 0, 0, 0));
    Instr = enc(3, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("midrst_flags", {4'b0000, ALUFlags}, 8'h00);
    check("midrst_dout", DataOut, 8'h00);
    @(posedge clk);
    #2 reset = 1'b1;
    step(enc(8, 0, 0, 8'h05));
    step(enc(14, 0, 0, 0));
    check("post_rst_r0", DataOut, 8'h05);

    for (int i = 0; i < 400; i++) begin
      step(16'($urandom));
      if (i % 8 == 7) step(enc(14, int'($urandom_range(0, 3)), 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
